// File: rtl/aes128_cbc_sequencer.sv
// rtl/aes128_cbc_sequencer.sv - AES-128 CBC message sequencer around an external cipher datapath
//
// Drives an AES-128 encryption core through a multi-block CBC message. It
// loads key and IV, waits out key expansion, and accepts one plaintext block
// at a time. It holds the core inputs for the pipeline latency, then presents
// the ciphertext on an output stream. It also owns the CBC chaining register.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_load     single-cycle pulse capturing cfg_key / cfg_iv (IDLE or READY only)
//   cfg_key      AES-128 key
//   cfg_iv       CBC initialisation vector
//   in_valid     plaintext block valid
//   in_ready     sequencer accepts a block (READY only)
//   in_data      plaintext block
//   in_last      final block of message, qualified by in_valid
//   out_valid    ciphertext block valid
//   out_ready    downstream accepts ciphertext
//   out_data     ciphertext block
//   out_last     final block of message
//   core_key     key to datapath (key register)
//   core_vector  chaining vector to datapath (IV or previous ciphertext)
//   core_plain   plaintext to datapath
//   core_cipher  ciphertext from datapath
//   key_ready    high in READY, BUSY and OUT
//   blk_cnt      index of current block within message
module aes128_cbc_sequencer #(
  parameter int unsigned KEY_LATENCY  = 12,
  parameter int unsigned CORE_LATENCY = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic [127:0] core_key,
  output logic [127:0] core_vector,
  output logic [127:0] core_plain,
  input  logic [127:0] core_cipher,
  output logic         key_ready,
  output logic [15:0]  blk_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_WAIT,
    ST_READY,
    ST_BUSY,
    ST_OUT
  } state_e;

  // Counters load latency-1 so that the state exits on the edge where the
  // counter reads zero, i.e. exactly LATENCY edges after the load edge.
  localparam logic [4:0] KEY_CNT_INIT  = 5'(KEY_LATENCY - 1);
  localparam logic [4:0] CORE_CNT_INIT = 5'(CORE_LATENCY - 1);

  state_e       state_q,     state_d;
  logic [4:0]   cnt_q,       cnt_d;
  logic [127:0] key_q,       key_d;
  logic [127:0] iv_q,        iv_d;
  logic [127:0] chain_q,     chain_d;
  logic [127:0] plain_q,     plain_d;
  logic         last_q,      last_d;
  logic [127:0] out_data_q,  out_data_d;
  logic         out_last_q,  out_last_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q,  in_ready_d;
  logic         key_ready_q, key_ready_d;
  logic [15:0]  blk_cnt_q,   blk_cnt_d;

  logic         load_cfg;

  // Reconfiguration is only honoured between blocks; mid-block pulses are
  // dropped so the block in flight completes under the key it started with.
  assign load_cfg = cfg_load && ((state_q == ST_IDLE) || (state_q == ST_READY));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    iv_d        = iv_q;
    chain_d     = chain_q;
    plain_d     = plain_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    key_ready_d = key_ready_q;
    blk_cnt_d   = blk_cnt_q;

    if (load_cfg) begin
      // cfg_load has priority over a coincident in_valid in READY.
      key_d       = cfg_key;
      iv_d        = cfg_iv;
      chain_d     = cfg_iv;
      blk_cnt_d   = 16'h0000;
      cnt_d       = KEY_CNT_INIT;
      in_ready_d  = 1'b0;
      key_ready_d = 1'b0;
      state_d     = ST_KEY_WAIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_KEY_WAIT: begin
          if (cnt_q == 5'd0) begin
            in_ready_d  = 1'b1;
            key_ready_d = 1'b1;
            state_d     = ST_READY;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end

        ST_READY: begin
          if (in_valid) begin
            plain_d    = in_data;
            last_d     = in_last;
            cnt_d      = CORE_CNT_INIT;
            in_ready_d = 1'b0;
            state_d    = ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (cnt_q == 5'd0) begin
            out_data_d  = core_cipher;
            out_last_d  = last_q;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            // End of message rewinds the chain to the IV so the next message
            // starts fresh under the same key without a reload.
            if (out_last_q) begin
              chain_d   = iv_q;
              blk_cnt_d = 16'h0000;
            end else begin
              chain_d   = out_data_q;
              blk_cnt_d = blk_cnt_q + 16'd1;
            end
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_READY;
          end
        end

        default: begin
          in_ready_d  = 1'b0;
          key_ready_d = 1'b0;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      key_q       <= '0;
      iv_q        <= '0;
      chain_q     <= '0;
      plain_q     <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      key_ready_q <= 1'b0;
      blk_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      chain_q     <= chain_d;
      plain_q     <= plain_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      key_ready_q <= key_ready_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign core_key    = key_q;
  assign core_vector = chain_q;
  assign core_plain  = plain_q;
  assign key_ready   = key_ready_q;
  assign blk_cnt     = blk_cnt_q;

endmodule

// File: tb/tb_aes128_cbc_sequencer.sv
// tb/tb_aes128_cbc_sequencer.sv - testbench for aes128_cbc_sequencer
module tb_aes128_cbc_sequencer;

  localparam int KL = 12;
  localparam int CL = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_load = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic [127:0] core_key;
  logic [127:0] core_vector;
  logic [127:0] core_plain;
  logic [127:0] core_cipher = '0;
  logic         key_ready;
  logic [15:0]  blk_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox [256];

  // Reference message state: key, IV, expected chaining vector, block index.
  logic [127:0] m_key = '0;
  logic [127:0] m_iv = '0;
  logic [127:0] m_chain = '0;
  logic [15:0]  m_blk = '0;

  aes128_cbc_sequencer #(.KEY_LATENCY(KL), .CORE_LATENCY(CL)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_key(core_key), .core_vector(core_vector), .core_plain(core_plain),
    .core_cipher(core_cipher), .key_ready(key_ready), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127 - 8*i -: 8];
      s[i] = pt[127 - 8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
      if (i % 16 == 0) begin
        tmp[0] = sbox[w[i - 3]] ^ rc;
        tmp[1] = sbox[w[i - 2]];
        tmp[2] = sbox[w[i - 1]];
        tmp[3] = sbox[w[i - 4]];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- behavioural cipher core ----------------
  // Ciphertext is only meaningful once plain/vector have been stable for CL
  // cycles and the key for KL cycles; otherwise a poison value is presented.
  logic [127:0] prev_key = '0;
  logic [127:0] prev_plain = '0;
  logic [127:0] prev_vec = '0;
  int           dstab = 0;
  int           kstab = 0;
  bit           cm_valid = 1'b0;

  always @(negedge clk) begin
    if (core_key !== prev_key) begin
      kstab = 1;
      cm_valid = 1'b0;
    end else if (kstab < 1000) kstab++;
    if (core_plain !== prev_plain || core_vector !== prev_vec) begin
      dstab = 1;
      cm_valid = 1'b0;
    end else if (dstab < 1000) dstab++;
    prev_key = core_key;
    prev_plain = core_plain;
    prev_vec = core_vector;
    if (dstab >= CL && kstab >= KL) begin
      if (!cm_valid) begin
        core_cipher = aes128(core_key, core_plain ^ core_vector);
        cm_valid = 1'b1;
      end
    end else begin
      core_cipher = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cfg(input logic [127:0] key, input logic [127:0] iv);
    cfg_key = key;
    cfg_iv = iv;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    m_key = key;
    m_iv = iv;
    m_chain = iv;
    m_blk = 16'h0000;
  endtask

  task automatic wait_ready(input string tag, input int exp_edges);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 128'(n), 128'(exp_edges));
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic last,
                           input int stall, input bit busy_pulse, output logic [127:0] ct);
    logic [127:0] exp;
    int n;
    bit stable;
    exp = aes128(m_key, pt ^ m_chain);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data = pt;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_data = rnd128();
    in_last = 1'($urandom);
    chk({tag, ".core_plain"}, core_plain, pt);
    chk({tag, ".core_vector"}, core_vector, m_chain);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (busy_pulse && n == 3) begin
        cfg_key = rnd128();
        cfg_iv = rnd128();
        cfg_load = 1'b1;
      end
      tick();
      cfg_load = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 128'(n), 128'(CL));
    chk({tag, ".out_data"}, out_data, exp);
    chk({tag, ".out_last"}, 128'(out_last), 128'(last));
    if (busy_pulse) chk({tag, ".key_after_busy_cfg"}, core_key, m_key);
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!(out_data === exp && out_last === last && core_plain === pt &&
            core_vector === m_chain && in_ready === 1'b0 && out_valid === 1'b1))
        stable = 1'b0;
    end
    if (stall > 0) chk({tag, ".stall_hold"}, 128'(stable), 128'(1));
    ct = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_chain = last ? m_iv : exp;
    m_blk = last ? 16'h0000 : m_blk + 16'd1;
    chk({tag, ".out_valid_fall"}, 128'(out_valid), 128'(0));
    chk({tag, ".in_ready_rise"}, 128'(in_ready), 128'(1));
    chk({tag, ".blk_cnt"}, 128'(blk_cnt), 128'(m_blk));
    chk({tag, ".chain"}, core_vector, m_chain);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(0));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, ".out_last"}, 128'(out_last), 128'(0));
    chk({tag, ".key_ready"}, 128'(key_ready), 128'(0));
    chk({tag, ".blk_cnt"}, 128'(blk_cnt), 128'(0));
    chk({tag, ".out_data"}, out_data, 128'(0));
    chk({tag, ".core_key"}, core_key, 128'(0));
    chk({tag, ".core_vector"}, core_vector, 128'(0));
    chk({tag, ".core_plain"}, core_plain, 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    logic [127:0] k;
    logic [127:0] iv;
    int nblk;
    int seen;
    bit lst;

    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      logic [7:0] inv;
      b = 8'(v);
      inv = 8'h00;
      if (b != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, b);
      end
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Reset state, with input noise that must be ignored.
    in_valid = 1'b1;
    in_data = rnd128();
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (5) tick();
    chk("idle_in_ready", 128'(in_ready), 128'(0));
    chk("idle_key_ready", 128'(key_ready), 128'(0));
    in_valid = 1'b0;

    // NIST SP800-38A F.2.1 two-block message.
    start_cfg(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f);
    wait_ready("nist_cfg_latency", KL);
    chk("nist_key_ready", 128'(key_ready), 128'(1));
    chk("nist_blk_cnt0", 128'(blk_cnt), 128'(0));
    run_block("nist0", 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 0, 1'b0, ct);
    chk("nist0_const", ct, 128'h7649abac8119b246cee98e9b12e9197d);
    run_block("nist1", 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 20, 1'b0, ct);
    chk("nist1_const", ct, 128'h5086cb9b507219ee95db113a917678b2);
    chk("nist_iv_restored", core_vector, 128'h000102030405060708090a0b0c0d0e0f);
    chk("nist_blk_cnt_end", 128'(blk_cnt), 128'(0));

    // cfg_load pulsed during KEY_WAIT is ignored.
    start_cfg(rnd128(), rnd128());
    repeat (3) tick();
    cfg_key = rnd128();
    cfg_iv = rnd128();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    wait_ready("kw_pulse_latency", KL - 4);
    chk("kw_pulse_key", core_key, m_key);

    // Randomized messages; message 1 is abandoned mid-way by a reload.
    for (int m = 0; m < 3; m++) begin
      if (m > 0) begin
        start_cfg(rnd128(), rnd128());
        wait_ready("rnd_cfg_latency", KL);
        chk("rnd_cfg_blk_cnt", 128'(blk_cnt), 128'(0));
      end
      nblk = $urandom_range(2, 4);
      for (int b = 0; b < nblk; b++) begin
        lst = (b == nblk - 1) && (m != 1);
        run_block("rnd", rnd128(), lst, $urandom_range(0, 6), (b == 1), ct);
      end
    end

    // Asynchronous reset in the 5th BUSY cycle.
    in_valid = 1'b1;
    in_data = rnd128();
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_reset_busy", 128'(in_ready), 128'(0));
    reset = 1'b0;
    #1;
    chk_all_zero("reset_busy");
    tick();
    reset = 1'b1;
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) seen++;
    end
    chk("post_reset_idle", 128'(seen), 128'(0));
    in_valid = 1'b0;
    start_cfg(rnd128(), rnd128());
    wait_ready("post_reset_cfg_latency", KL);

    // cfg_load coincident with in_valid in READY: cfg_load wins.
    pt = rnd128();
    k = rnd128();
    iv = rnd128();
    in_valid = 1'b1;
    in_data = pt;
    in_last = 1'b1;
    start_cfg(k, iv);
    chk("coll_in_ready", 128'(in_ready), 128'(0));
    chk("coll_key_ready", 128'(key_ready), 128'(0));
    chk("coll_core_key", core_key, k);
    chk("coll_not_accepted", core_plain, 128'(0));
    wait_ready("coll_latency", KL);
    run_block("coll", pt, 1'b1, 2, 1'b0, ct);
    chk("coll_new_key_ct", ct, aes128(k, pt ^ iv));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
